dma_channel_arbiter: RTL and testbench

DMA_CHANNEL_ARBITER -- requirements
Module: dma_channel_arbiter

---
 rtl/dma_channel_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_dma_channel_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_channel_arbiter.sv
// Four-channel DMA arbiter: bus hold handshake, fixed/rotating priority,
// per-channel transfer counters with terminal-count pulses.
module dma_channel_arbiter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       DREQ,
    input  logic [3:0]       MASK,
    input  logic             ROTATE,
    input  logic             CFG_WE,
    input  logic [1:0]       CFG_CH,
    input  logic [CNT_W-1:0] CFG_COUNT,
    input  logic             HLDA,
    output logic             HRQ,
    output logic [3:0]       DACK,
    output logic [1:0]       GRANT_CH,
    output logic             XFER,
    output logic [3:0]       TC,
    output logic             EOP
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_REQ = 2'd1,
        GRANT    = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count [4];
    logic [1:0]       r_ptr;
    logic [1:0]       r_grant_ch;
    logic [3:0]       r_dack;
    logic [3:0]       r_tc;
    logic             r_hrq;
    logic             r_xfer;
    logic             r_eop;

    logic [3:0]       w_elig;
    logic [1:0]       w_winner;
    logic [1:0]       w_rot_idx;
    logic [1:0]       w_ptr_nxt;
    logic [1:0]       w_grant_ch_nxt;
    logic [3:0]       w_dack_nxt;
    logic [3:0]       w_tc_nxt;
    logic             w_hrq_nxt;
    logic             w_xfer_nxt;
    logic             w_dec;
    logic             w_last;
    logic             w_cfg_block;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            w_elig[n] = DREQ[n] & ~MASK[n] & (r_count[n] != '0);
        end
    end

    // Later loop iterations have higher priority, so the last hit wins.
    always_comb begin
        w_winner  = 2'd0;
        w_rot_idx = 2'd0;
        if (!ROTATE) begin
            for (int i = 3; i >= 0; i--) begin
                if (w_elig[i]) w_winner = 2'(i);
            end
        end else begin
            for (int k = 4; k >= 1; k--) begin
                w_rot_idx = r_ptr + 2'(k);
                if (w_elig[w_rot_idx]) w_winner = w_rot_idx;
            end
        end
    end

    assign w_last      = (r_count[r_grant_ch] == CNT_W'(1));
    assign w_cfg_block = (r_state == GRANT) && (CFG_CH == r_grant_ch);

    always_comb begin
        w_state_nxt    = r_state;
        w_hrq_nxt      = r_hrq;
        w_dack_nxt     = r_dack;
        w_grant_ch_nxt = r_grant_ch;
        w_ptr_nxt      = r_ptr;
        w_xfer_nxt     = 1'b0;
        w_tc_nxt       = 4'b0000;
        w_dec          = 1'b0;
        case (r_state)
            IDLE: begin
                w_hrq_nxt  = 1'b0;
                w_dack_nxt = 4'b0000;
                if (|w_elig) begin
                    w_state_nxt = HOLD_REQ;
                    w_hrq_nxt   = 1'b1;
                end
            end
            HOLD_REQ: begin
                w_hrq_nxt = 1'b1;
                if (HLDA) begin
                    if (|w_elig) begin
                        w_state_nxt    = GRANT;
                        w_grant_ch_nxt = w_winner;
                        w_dack_nxt     = 4'b0001 << w_winner;
                    end else begin
                        w_state_nxt = RELEASE;
                        w_hrq_nxt   = 1'b0;
                    end
                end
            end
            GRANT: begin
                if (!HLDA || !DREQ[r_grant_ch] || MASK[r_grant_ch] ||
                    (r_count[r_grant_ch] == '0)) begin
                    w_state_nxt = RELEASE;
                    w_hrq_nxt   = 1'b0;
                    w_dack_nxt  = 4'b0000;
                    w_ptr_nxt   = r_grant_ch;
                end else begin
                    w_dec      = 1'b1;
                    w_xfer_nxt = 1'b1;
                    if (w_last) begin
                        w_tc_nxt    = 4'b0001 << r_grant_ch;
                        w_state_nxt = RELEASE;
                        w_hrq_nxt   = 1'b0;
                        w_dack_nxt  = 4'b0000;
                        w_ptr_nxt   = r_grant_ch;
                    end
                end
            end
            RELEASE: begin
                w_hrq_nxt  = 1'b0;
                w_dack_nxt = 4'b0000;
                if (!HLDA) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_hrq_nxt   = 1'b0;
                w_dack_nxt  = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_hrq      <= 1'b0;
            r_dack     <= 4'b0000;
            r_grant_ch <= 2'd0;
            r_ptr      <= 2'd3;
            r_xfer     <= 1'b0;
            r_tc       <= 4'b0000;
            r_eop      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hrq      <= w_hrq_nxt;
            r_dack     <= w_dack_nxt;
            r_grant_ch <= w_grant_ch_nxt;
            r_ptr      <= w_ptr_nxt;
            r_xfer     <= w_xfer_nxt;
            r_tc       <= w_tc_nxt;
            r_eop      <= |w_tc_nxt;
        end
    end

    // A write aimed at the channel currently owning the bus is discarded.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int n = 0; n < 4; n++) r_count[n] <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (w_dec && (r_grant_ch == 2'(n))) begin
                    r_count[n] <= r_count[n] - CNT_W'(1);
                end else if (CFG_WE && (CFG_CH == 2'(n)) && !w_cfg_block) begin
                    r_count[n] <= CFG_COUNT;
                end
            end
        end
    end

    assign HRQ      = r_hrq;
    assign DACK     = r_dack;
    assign GRANT_CH = r_grant_ch;
    assign XFER     = r_xfer;
    assign TC       = r_tc;
    assign EOP      = r_eop;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Bench for dma_channel_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_dma_channel_arbiter;

    localparam int unsigned CNT_W = 8;

    logic             CLK = 1'b0;
    logic             RST;
    logic [3:0]       DREQ;
    logic [3:0]       MASK;
    logic             ROTATE;
    logic             CFG_WE;
    logic [1:0]       CFG_CH;
    logic [CNT_W-1:0] CFG_COUNT;
    logic             HLDA;
    logic             HRQ;
    logic [3:0]       DACK;
    logic [1:0]       GRANT_CH;
    logic             XFER;
    logic [3:0]       TC;
    logic             EOP;

    dma_channel_arbiter #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .DREQ(DREQ), .MASK(MASK), .ROTATE(ROTATE),
        .CFG_WE(CFG_WE), .CFG_CH(CFG_CH), .CFG_COUNT(CFG_COUNT), .HLDA(HLDA),
        .HRQ(HRQ), .DACK(DACK), .GRANT_CH(GRANT_CH), .XFER(XFER), .TC(TC), .EOP(EOP)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: phase 0 idle, 1 asking for bus, 2 channel owns bus, 3 giving bus back
    int       m_cnt [4];
    int       m_ptr;
    int       m_phase;
    int       m_owner;
    bit       m_hrq;
    bit [3:0] m_dack;
    int       m_gch;
    bit       m_xfer;
    bit [3:0] m_tc;

    int       n_xfer;
    bit [3:0] tc_seen;
    int       grants[$];
    int       exp_q[$];
    logic [3:0] prev_dack = 4'b0000;
    int       hq_age = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int pick(input bit [3:0] el, input bit rot, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = rot ? (ptr + k) % 4 : k - 1;
            if (el[c]) return c;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < 4; n++) m_cnt[n] = 0;
        m_ptr = 3; m_phase = 0; m_owner = 0; m_hrq = 0;
        m_dack = 0; m_gch = 0; m_xfer = 0; m_tc = 0;
    endfunction

    function automatic void model_edge();
        bit [3:0] el;
        int ph;
        int w;
        for (int n = 0; n < 4; n++) el[n] = DREQ[n] && !MASK[n] && (m_cnt[n] != 0);
        ph = m_phase;
        m_xfer = 0;
        m_tc = 0;
        case (ph)
            0: if (el != 0) begin m_phase = 1; m_hrq = 1; end
            1: if (HLDA) begin
                w = pick(el, ROTATE, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_gch = w; m_dack = 4'(1 << w); m_phase = 2;
                end else begin
                    m_hrq = 0; m_phase = 3;
                end
            end
            2: begin
                if (HLDA && DREQ[m_owner] && !MASK[m_owner] && m_cnt[m_owner] > 0) begin
                    m_cnt[m_owner]--;
                    m_xfer = 1;
                    if (m_cnt[m_owner] == 0) m_tc[m_owner] = 1'b1;
                end
                if (!m_xfer || m_tc != 0) begin
                    m_dack = 0; m_hrq = 0; m_ptr = m_owner; m_phase = 3;
                end
            end
            default: if (!HLDA) m_phase = 0;
        endcase
        if (CFG_WE && !(ph == 2 && int'(CFG_CH) == m_owner)) m_cnt[CFG_CH] = int'(CFG_COUNT);
    endfunction

    task automatic step();
        @(posedge CLK);
        if (RST) model_reset(); else model_edge();
        #1;
        check_val("HRQ", 32'(HRQ), 32'(m_hrq));
        check_val("DACK", 32'(DACK), 32'(m_dack));
        check_val("GRANT_CH", 32'(GRANT_CH), 32'(m_gch));
        check_val("XFER", 32'(XFER), 32'(m_xfer));
        check_val("TC", 32'(TC), 32'(m_tc));
        check_val("EOP", 32'(EOP), 32'(|m_tc));
        n_xfer += int'(XFER);
        tc_seen |= TC;
        if (DACK != 4'b0000 && prev_dack == 4'b0000) grants.push_back(int'(GRANT_CH));
        prev_dack = DACK;
    endtask

    // CPU that grants the bus lat cycles after HRQ and drops HLDA once HRQ falls
    task automatic run(input int n, input int lat);
        repeat (n) begin
            step();
            if (m_hrq) hq_age++; else hq_age = 0;
            HLDA = m_hrq && (hq_age >= lat);
        end
    endtask

    task automatic cfg(input int ch, input int val);
        CFG_WE = 1'b1; CFG_CH = 2'(ch); CFG_COUNT = CNT_W'(val);
        run(1, 1);
        CFG_WE = 1'b0;
    endtask

    task automatic clear_obs();
        n_xfer = 0; tc_seen = 0; grants.delete();
    endtask

    task automatic check_order(input string tag);
        check_val({tag, "_len"}, 32'(grants.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < grants.size(); i++)
            check_val(tag, 32'(grants[i]), 32'(exp_q[i]));
    endtask

    task automatic run_until_xfer(input int target, input int budget);
        int k = 0;
        while (n_xfer < target && k < budget) begin run(1, 1); k++; end
        check_val("xfer_reached", 32'(n_xfer >= target), 32'd1);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        RST = 1'b1;
        #1;
        check_val("rst_HRQ", 32'(HRQ), 32'd0);
        check_val("rst_DACK", 32'(DACK), 32'd0);
        check_val("rst_XFER", 32'(XFER), 32'd0);
        check_val("rst_TC", 32'(TC), 32'd0);
        check_val("rst_EOP", 32'(EOP), 32'd0);
        check_val("rst_GRANT_CH", 32'(GRANT_CH), 32'd0);
        model_reset();
        HLDA = 1'b0; hq_age = 0;
        step();
        RST = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int wait_cnt = 0;
        int b;
        RST = 1'b1; DREQ = 0; MASK = 0; ROTATE = 0; CFG_WE = 0; CFG_CH = 0;
        CFG_COUNT = 0; HLDA = 0;
        model_reset();
        step(); step();
        RST = 1'b0;
        check_val("reset_HRQ", 32'(HRQ), 32'd0);
        check_val("reset_DACK", 32'(DACK), 32'd0);

        // single channel, count 3, HLDA two cycles behind HRQ
        cfg(0, 3);
        clear_obs();
        DREQ = 4'b0001;
        run(12, 2);
        check_val("t1_xfers", 32'(n_xfer), 32'd3);
        check_val("t1_tc", 32'(tc_seen), 32'b0001);
        exp_q = '{0};
        check_order("t1_order");
        check_val("t1_hrq_idle", 32'(HRQ), 32'd0);
        DREQ = 0;
        run(3, 1);

        // fixed priority, all counts 2
        ROTATE = 0;
        for (int c = 0; c < 4; c++) cfg(c, 2);
        clear_obs();
        DREQ = 4'b1111;
        run(40, 1);
        check_val("t2_xfers", 32'(n_xfer), 32'd8);
        check_val("t2_tc", 32'(tc_seen), 32'b1111);
        exp_q = '{0, 1, 2, 3};
        check_order("t2_order");

        // rotating priority from reset pointer
        DREQ = 0;
        do_reset();
        ROTATE = 1;
        for (int c = 0; c < 4; c++) cfg(c, 1);
        clear_obs();
        DREQ = 4'b1111;
        run(30, 1);
        DREQ = 0;
        cfg(2, 1);
        DREQ = 4'b1111;
        run(10, 1);
        DREQ = 0;
        cfg(3, 1);
        cfg(0, 1);
        DREQ = 4'b1001;
        run(20, 1);
        exp_q = '{0, 1, 2, 3, 2, 3, 0};
        check_order("t3_order");

        // demand release after two transfers, then resume
        DREQ = 0; ROTATE = 0;
        cfg(1, 5);
        clear_obs();
        DREQ = 4'b0010;
        run_until_xfer(2, 20);
        DREQ = 0;
        run(4, 1);
        check_val("t4_dack_clear", 32'(DACK), 32'd0);
        check_val("t4_no_tc", 32'(tc_seen), 32'd0);
        clear_obs();
        DREQ = 4'b0010;
        run(20, 1);
        check_val("t4_rest_xfers", 32'(n_xfer), 32'd3);
        check_val("t4_tc", 32'(tc_seen), 32'b0010);

        // bus revoked after one transfer; write to owner during grant dropped
        DREQ = 0;
        cfg(2, 4);
        clear_obs();
        DREQ = 4'b0100;
        run_until_xfer(1, 20);
        HLDA = 0;
        step();
        check_val("t5_dack_revoked", 32'(DACK), 32'd0);
        check_val("t5_no_eop", 32'(EOP), 32'd0);
        hq_age = 0;
        begin
            int k = 0;
            while (DACK == 4'b0000 && k < 20) begin run(1, 1); k++; end
        end
        check_val("t5_regrant", 32'(DACK), 32'b0100);
        clear_obs();
        cfg(2, 9);
        run(20, 1);
        check_val("t5_rest_xfers", 32'(n_xfer), 32'd3);
        check_val("t5_tc", 32'(tc_seen), 32'b0100);

        // reset mid-grant clears counts
        DREQ = 0;
        cfg(3, 5);
        clear_obs();
        DREQ = 4'b1000;
        run_until_xfer(1, 20);
        do_reset();
        DREQ = 4'b1111;
        run(6, 1);
        check_val("t6_hrq_zero_counts", 32'(HRQ), 32'd0);
        check_val("t6_no_tc", 32'(tc_seen), 32'd0);

        // randomized traffic
        DREQ = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if ($urandom_range(0, 3) == 0) begin b = $urandom_range(0, 3); DREQ[b] = ~DREQ[b]; end
            if ($urandom_range(0, 19) == 0) begin b = $urandom_range(0, 3); MASK[b] = ~MASK[b]; end
            if ($urandom_range(0, 99) == 0) ROTATE = ~ROTATE;
            CFG_WE    = ($urandom_range(0, 5) == 0);
            CFG_CH    = 2'($urandom_range(0, 3));
            CFG_COUNT = CNT_W'($urandom_range(0, 4));
            if (m_hrq) begin
                if (!HLDA) begin
                    if (wait_cnt == 0) begin HLDA = 1; wait_cnt = $urandom_range(0, 2); end
                    else wait_cnt--;
                end else if (m_phase == 2 && $urandom_range(0, 30) == 0) begin
                    HLDA = 0; wait_cnt = $urandom_range(0, 2);
                end
            end else begin
                if (HLDA) begin
                    if (wait_cnt == 0) HLDA = 0; else wait_cnt--;
                end else wait_cnt = $urandom_range(0, 3);
            end
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                wait_cnt = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
